// File: rtl/exec_unit.sv
// exec_unit: opcode decoder, 32-bit ALU and 256-word data memory for the
// 4-bit-opcode pipelined CPU. Sits between the ID/EX and EX/WB buffers.
// Optional feature macro: EXU_BRANCH_RESOLVE_EN
//   defined   -> branch_taken resolved here from z/n/jump
//   undefined -> branch_taken tied low, resolution done externally
module exec_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] xrs,
  input  logic [DATA_W-1:0] xrt,
  input  logic [DATA_W-1:0] y,
  output logic [2:0]        alu_op,
  output logic              mem_read,
  output logic              mem_write,
  output logic              alu_src,
  output logic [1:0]        wb_ctrl,
  output logic              reg_wrt,
  output logic              branch_zero,
  output logic              branch_neg,
  output logic              jump,
  output logic              jump_mem,
  output logic [DATA_W-1:0] alu_result,
  output logic              z,
  output logic              n,
  output logic [DATA_W-1:0] read_data,
  output logic              branch_taken
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] operand_b;
  logic [ADDR_W-1:0] addr;

  // Upper address bits are dropped so accesses wrap modulo DEPTH.
  assign addr = ADDR_W'(xrs);

  // Decode the opcode into pipeline control bits; unknown opcodes act as NOP.
  always_comb begin
    alu_op      = 3'b000;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_src     = 1'b0;
    wb_ctrl     = 2'b00;
    reg_wrt     = 1'b0;
    branch_zero = 1'b0;
    branch_neg  = 1'b0;
    jump        = 1'b0;
    jump_mem    = 1'b0;
    case (opcode)
      4'b1111: reg_wrt = 1'b1;
      4'b1110: begin
        mem_read = 1'b1;
        reg_wrt  = 1'b1;
        wb_ctrl  = 2'b01;
      end
      4'b0011: mem_write = 1'b1;
      4'b0100: begin
        reg_wrt = 1'b1;
        wb_ctrl = 2'b10;
      end
      4'b0101: begin
        alu_src = 1'b1;
        reg_wrt = 1'b1;
        wb_ctrl = 2'b10;
      end
      4'b0110: begin
        alu_op  = 3'b010;
        reg_wrt = 1'b1;
        wb_ctrl = 2'b10;
      end
      4'b0111: begin
        alu_op  = 3'b001;
        reg_wrt = 1'b1;
        wb_ctrl = 2'b10;
      end
      4'b1000: jump = 1'b1;
      4'b1001: begin
        branch_zero = 1'b1;
        alu_op      = 3'b011;
      end
      4'b1010: begin
        jump     = 1'b1;
        jump_mem = 1'b1;
        mem_read = 1'b1;
      end
      4'b1011: begin
        branch_neg = 1'b1;
        alu_op     = 3'b011;
      end
      default: ;
    endcase
  end

  // ALU: modulo-2^DATA_W arithmetic on A=xrs and the selected B operand.
  always_comb begin
    operand_b = alu_src ? y : xrt;
    case (alu_op)
      3'b000:  alu_result = xrs + operand_b;
      3'b001:  alu_result = xrs - operand_b;
      3'b010:  alu_result = '0 - xrs;
      3'b011:  alu_result = xrs;
      default: alu_result = operand_b;
    endcase
  end

  assign z = (alu_result == '0);
  assign n = alu_result[DATA_W-1];

  // Data memory: reset clears every word and discards a same-cycle write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[addr] <= xrt;
    end
  end

  // Asynchronous read; a same-address write shows up only after the edge.
  assign read_data = mem_read ? mem[addr] : '0;

`ifdef EXU_BRANCH_RESOLVE_EN
  assign branch_taken = (branch_zero & z) | (branch_neg & n) | jump;
`else
  assign branch_taken = 1'b0;
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases with literal expectations
// plus randomized instructions compared against a behavioural model.
module tb_exec_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [31:0] xrs, xrt, y;
  logic [2:0]  alu_op;
  logic        mem_read, mem_write, alu_src, reg_wrt;
  logic [1:0]  wb_ctrl;
  logic        branch_zero, branch_neg, jump, jump_mem;
  logic [31:0] alu_result, read_data;
  logic        z, n, branch_taken;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] m_mem [256];

  exec_unit #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .xrs(xrs), .xrt(xrt), .y(y),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .wb_ctrl(wb_ctrl), .reg_wrt(reg_wrt), .branch_zero(branch_zero),
    .branch_neg(branch_neg), .jump(jump), .jump_mem(jump_mem),
    .alu_result(alu_result), .z(z), .n(n), .read_data(read_data),
    .branch_taken(branch_taken)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] op;
    logic       mr, mw, src;
    logic [1:0] wb;
    logic       rw, bz, bn, j, jm;
  } ctrl_t;

  // Instruction table, one row per mnemonic.
  function automatic ctrl_t model_ctrl(input logic [3:0] o);
    ctrl_t c = '0;
    case (o)
      4'hF: c.rw = 1'b1;
      4'hE: begin c.mr = 1'b1; c.rw = 1'b1; c.wb = 2'b01; end
      4'h3: c.mw = 1'b1;
      4'h4: begin c.rw = 1'b1; c.wb = 2'b10; end
      4'h5: begin c.src = 1'b1; c.rw = 1'b1; c.wb = 2'b10; end
      4'h6: begin c.op = 3'b010; c.rw = 1'b1; c.wb = 2'b10; end
      4'h7: begin c.op = 3'b001; c.rw = 1'b1; c.wb = 2'b10; end
      4'h8: c.j = 1'b1;
      4'h9: begin c.bz = 1'b1; c.op = 3'b011; end
      4'hA: begin c.j = 1'b1; c.jm = 1'b1; c.mr = 1'b1; end
      4'hB: begin c.bn = 1'b1; c.op = 3'b011; end
      default: ;
    endcase
    return c;
  endfunction

  // Arithmetic meaning of each instruction; everything else computes xrs+xrt.
  function automatic logic [31:0] model_alu(input logic [3:0] o, input logic [31:0] a, b, im);
    case (o)
      4'h5:       return a + im;
      4'h6:       return -a;
      4'h7:       return a - b;
      4'h9, 4'hB: return a;
      default:    return a + b;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (op=%h xrs=%h xrt=%h y=%h rst=%b)",
               nm, act, exp, opcode, xrs, xrt, y, reset);
    end
  endtask

  // Compare every output against the model for the currently applied inputs.
  task automatic check_all();
    ctrl_t       c;
    logic [31:0] r, rd;
    logic        ez, en, bt;
    c  = model_ctrl(opcode);
    r  = model_alu(opcode, xrs, xrt, y);
    ez = (r == 32'h0);
    en = r[31];
    rd = c.mr ? m_mem[xrs[7:0]] : 32'h0;
`ifdef EXU_BRANCH_RESOLVE_EN
    bt = (c.bz & ez) | (c.bn & en) | c.j;
`else
    bt = 1'b0;
`endif
    cmp("alu_op",       32'(alu_op),      32'(c.op));
    cmp("mem_read",     32'(mem_read),    32'(c.mr));
    cmp("mem_write",    32'(mem_write),   32'(c.mw));
    cmp("alu_src",      32'(alu_src),     32'(c.src));
    cmp("wb_ctrl",      32'(wb_ctrl),     32'(c.wb));
    cmp("reg_wrt",      32'(reg_wrt),     32'(c.rw));
    cmp("branch_zero",  32'(branch_zero), 32'(c.bz));
    cmp("branch_neg",   32'(branch_neg),  32'(c.bn));
    cmp("jump",         32'(jump),        32'(c.j));
    cmp("jump_mem",     32'(jump_mem),    32'(c.jm));
    cmp("alu_result",   alu_result,       r);
    cmp("z",            32'(z),           32'(ez));
    cmp("n",            32'(n),           32'(en));
    cmp("read_data",    read_data,        rd);
    cmp("branch_taken", 32'(branch_taken), 32'(bt));
  endtask

  // Reference memory follows the same clock edge as the DUT.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    end else if (opcode == 4'h3) begin
      m_mem[xrs[7:0]] = xrt;
    end
  end

  task automatic drive(input logic r, input logic [3:0] o, input logic [31:0] a, b, im);
    @(negedge clock);
    reset = r; opcode = o; xrs = a; xrt = b; y = im;
    #1;
    check_all();
  endtask

  logic exp_bt;

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    reset = 1'b1; opcode = 4'h0; xrs = '0; xrt = '0; y = '0;

    // Reset, then LD from address 5 sees a cleared word.
    drive(1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    cmp("rst_alu_result", alu_result, 32'h0);
    cmp("rst_z", 32'(z), 32'h1);
    drive(1'b0, 4'hE, 32'h5, 32'h0, 32'h0);
    cmp("ld0_read_data", read_data, 32'h0);
    cmp("ld0_mem_read", 32'(mem_read), 32'h1);
    cmp("ld0_wb", 32'(wb_ctrl), 32'h1);

    // Store through a wrapped address, read back at the low alias.
    drive(1'b0, 4'h3, 32'h105, 32'hDEADBEEF, 32'h0);
    cmp("st_read_data", read_data, 32'h0);
    drive(1'b0, 4'hE, 32'h5, 32'h0, 32'h0);
    cmp("ld_wrap", read_data, 32'hDEADBEEF);

    // A store coinciding with reset is discarded, and memory is cleared.
    drive(1'b1, 4'h3, 32'h7, 32'h12345678, 32'h0);
    drive(1'b0, 4'hE, 32'h7, 32'h0, 32'h0);
    cmp("rst_store_dropped", read_data, 32'h0);
    drive(1'b0, 4'hE, 32'h5, 32'h0, 32'h0);
    cmp("rst_clears", read_data, 32'h0);

    drive(1'b0, 4'h7, 32'd7, 32'd7, 32'h0);
    cmp("sub_res", alu_result, 32'h0);
    cmp("sub_z", 32'(z), 32'h1);
    cmp("sub_n", 32'(n), 32'h0);

    drive(1'b0, 4'h6, 32'd1, 32'h0, 32'h0);
    cmp("neg_res", alu_result, 32'hFFFFFFFF);
    cmp("neg_n", 32'(n), 32'h1);

    drive(1'b0, 4'h5, 32'd10, 32'h0, 32'hFFFFFFFE);
    cmp("inc_res", alu_result, 32'd8);
    cmp("inc_src", 32'(alu_src), 32'h1);

    drive(1'b0, 4'h1, 32'h55, 32'h66, 32'h77);
    cmp("op1_ctrl", {22'h0, alu_op, mem_read, mem_write, alu_src, wb_ctrl, reg_wrt,
                     branch_zero, branch_neg, jump}, 32'h0);
    cmp("op1_jm", 32'(jump_mem), 32'h0);

`ifdef EXU_BRANCH_RESOLVE_EN
    exp_bt = 1'b1;
`else
    exp_bt = 1'b0;
`endif
    drive(1'b0, 4'hB, 32'h80000000, 32'h0, 32'h0);
    cmp("brn_taken", 32'(branch_taken), 32'(exp_bt));
    drive(1'b0, 4'hA, 32'h5, 32'h0, 32'h0);
    cmp("jm_jump", 32'(jump), 32'h1);
    cmp("jm_jump_mem", 32'(jump_mem), 32'h1);

    // Randomized instruction stream; addresses biased to a few words to get reuse.
    for (int k = 0; k < 800; k++) begin
      logic [31:0] a, b, im;
      logic        r;
      a  = $urandom;
      b  = $urandom;
      im = $urandom;
      if ($urandom_range(0, 3) != 0) a[7:0] = 8'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: b = a;
        1: im = -a;
        2: a = 32'h0;
        default: ;
      endcase
      r = ($urandom_range(0, 63) == 0);
      drive(r, 4'($urandom_range(0, 15)), a, b, im);
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
